stochastic_bit_generator: RTL and testbench

- Downstream consumer of the 1-bit serial pseudorandom output of the 64-bit Fibonacci LFSR.
- Deserializes WIDTH consecutive random bits into a word.
- Compares the word against a programmable probability and emits one stochastic bitstream sample per word over a valid/ready handshake.
- Sits between the LFSR and the stochastic arithmetic operators; it is the SNG front end of the bitstream datapath.

---
 rtl/sc_pkg.sv | 8 +
 rtl/serial_deserializer.sv | 29 ++
 rtl/stochastic_bit_generator.sv | 58 +++++
 tb/tb_stochastic_bit_generator.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// sc_pkg: shared width, probability type and counter-width helper for the stochastic datapath
package sc_pkg;
    localparam int SC_WIDTH = 8;
    typedef logic [SC_WIDTH-1:0] prob_t;
    function automatic int CNT_W(input int w);
        return $clog2(w);
    endfunction
endpackage

// File: rtl/serial_deserializer.sv
// serial_deserializer: gathers WIDTH serial random bits into a word, newest bit at the LSB
module serial_deserializer
    import sc_pkg::*;
#(
    parameter int WIDTH = SC_WIDTH
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             rand_bit,
    input  logic             hold,
    output logic             done,
    output logic [WIDTH-1:0] word
);
    localparam int CW = CNT_W(WIDTH);
    logic [WIDTH-2:0] sr;
    logic [CW-1:0]    cnt;
    // The live bit completes the word combinationally, so no extra cycle is spent at the boundary.
    assign word = {sr, rand_bit};
    assign done = cnt == CW'(WIDTH - 1);
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            sr  <= '0;
            cnt <= '0;
        end else if (!hold) begin
            sr  <= word[WIDTH-2:0];
            cnt <= done ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/stochastic_bit_generator.sv
// stochastic_bit_generator: turns serial LFSR bits into one (word < p) bitstream sample per word
module stochastic_bit_generator
    import sc_pkg::*;
#(
    parameter int               WIDTH        = SC_WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_PROB = WIDTH'(8'h80)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             rand_bit,
    input  logic [WIDTH-1:0] prob_in,
    input  logic             prob_load,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             out_bit,
    output logic             prob_pending
);
    logic             done;
    logic             stall;
    logic             complete;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] prob_active;
    logic [WIDTH-1:0] prob_shadow;
    assign stall    = done & out_valid & ~out_ready;
    assign complete = done & ~stall;
    serial_deserializer #(.WIDTH(WIDTH)) u_des (
        .CLK      (CLK),
        .nRST     (nRST),
        .rand_bit (rand_bit),
        .hold     (stall),
        .done     (done),
        .word     (word)
    );
    // Probability only switches at a word boundary, after the boundary's compare.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            out_valid    <= 1'b0;
            out_bit      <= 1'b0;
            prob_active  <= DEFAULT_PROB;
            prob_shadow  <= DEFAULT_PROB;
            prob_pending <= 1'b0;
        end else begin
            if (prob_load)
                prob_shadow <= prob_in;
            if (complete) begin
                out_bit      <= word < prob_active;
                out_valid    <= 1'b1;
                prob_active  <= prob_load ? prob_in : prob_shadow;
                prob_pending <= 1'b0;
            end else begin
                if (out_valid && out_ready)
                    out_valid <= 1'b0;
                if (prob_load)
                    prob_pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stochastic_bit_generator.sv
// tb_stochastic_bit_generator: scoreboard bench for the SNG front end at WIDTH=8
module tb_stochastic_bit_generator;
    localparam int W = 8;
    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic         rand_bit = 1'b0;
    logic [W-1:0] prob_in = '0;
    logic         prob_load = 1'b0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic         out_bit;
    logic         prob_pending;
    int n_checks = 0;
    int n_fail = 0;
    bit exp_q[$];
    int           m_cnt = 0;
    logic [W-1:0] m_word = '0;
    logic [W-1:0] m_active = 8'h80;
    logic [W-1:0] m_shadow = 8'h80;
    bit           m_valid = 0;
    bit           m_pending = 0;

    always #5 CLK = ~CLK;

    stochastic_bit_generator #(.WIDTH(W), .DEFAULT_PROB(8'h80)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .rand_bit     (rand_bit),
        .prob_in      (prob_in),
        .prob_load    (prob_load),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_bit      (out_bit),
        .prob_pending (prob_pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drives one cycle at the falling edge and advances the reference model to the next rising edge.
    task automatic step(input bit rb, input bit rdy, input bit ld = 0,
                        input logic [W-1:0] p = '0, input bit rst_n = 1);
        bit done;
        bit stall;
        @(negedge CLK);
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("prob_pending", {31'd0, prob_pending}, {31'd0, m_pending});
        nRST = rst_n;
        rand_bit = rb;
        out_ready = rdy;
        prob_load = ld;
        prob_in = p;
        if (!rst_n) begin
            m_cnt = 0;
            m_word = '0;
            m_valid = 0;
            m_pending = 0;
            m_active = 8'h80;
            m_shadow = 8'h80;
            exp_q.delete();
        end else begin
            done = (m_cnt == W - 1);
            stall = done && m_valid && !rdy;
            if (m_valid && rdy) begin
                if (exp_q.size() == 0)
                    check("scoreboard_empty", 32'd1, 32'd0);
                else
                    check("out_bit", {31'd0, out_bit}, {31'd0, exp_q.pop_front()});
            end
            if (ld) begin
                m_shadow = p;
                m_pending = 1;
            end
            if (!stall) begin
                m_word = {m_word[W-2:0], rb};
                if (done) begin
                    exp_q.push_back(m_word < m_active);
                    m_active = m_shadow;
                    m_pending = 0;
                    m_cnt = 0;
                    m_valid = 1;
                end else begin
                    m_cnt++;
                    if (m_valid && rdy)
                        m_valid = 0;
                end
            end
        end
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit ld, input logic [W-1:0] p);
        for (int i = W - 1; i >= 0; i--)
            step(w[i], 1, (i == W - 1) ? ld : 1'b0, p);
    endtask

    initial begin
        repeat (3) step(0, 1, 0, '0, 0);
        // all ones against default 0x80, then against 0xFF
        repeat (8) step(1, 1);
        step(1, 1, 1, 8'hFF);
        repeat (15) step(1, 1);
        // all zeros against 0x01, then 0x00
        step(0, 1, 1, 8'h01);
        repeat (23) step(0, 1);
        step(0, 1, 1, 8'h00);
        repeat (15) step(0, 1);
        // word 0xB2 at the compare boundary
        send_word(8'hB2, 1, 8'hB3);
        send_word(8'hB2, 0, '0);
        send_word(8'hB2, 1, 8'hB2);
        send_word(8'hB2, 0, '0);
        // stall: one held sample, further bits ignored
        repeat (28) step(1'($urandom), 0);
        step(1'($urandom), 1);
        repeat (8) step(1'($urandom), 1);
        // load mid-word at cnt=3
        repeat (3) step(1'($urandom), 1);
        step(1'($urandom), 1, 1, 8'h10);
        repeat (4) step(1'($urandom), 1);
        send_word(8'h0F, 0, '0);
        // load coincident with the boundary
        repeat (7) step(1'($urandom), 1);
        step(1'($urandom), 1, 1, 8'hF0);
        send_word(8'hEF, 0, '0);
        send_word(8'hF0, 0, '0);
        // reset at cnt=5 with an unconsumed sample
        repeat (5) step(1'($urandom), 0);
        step(1'($urandom), 0, 0, '0, 0);
        repeat (10) step(1'($urandom), 1);
        // random traffic
        for (int i = 0; i < 300; i++)
            step(1'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 9) == 0), W'($urandom));
        step(0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
